// File: rtl/tlb_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_refill_ctrl
//  Purpose  : Hardware TLB refill controller for the memory stage. On a TLB
//             miss it holds the pipeline, fetches the page-table entry (PTE)
//             for the missing virtual page and writes the translation into
//             the TLB. An invalid PTE is reported as a page fault. When the
//             optional timeout is built, an unanswered PTE read is also
//             reported as a page fault.
//
//  Build option:
//    TLB_REFILL_TIMEOUT_EN  - when defined, a wait counter aborts a PTE
//                             read after TIMEOUT_CYCLES cycles without
//                             mem_ack_i (fault code 1). When undefined,
//                             the read waits forever and fault_code_o is 0.
//
//  Parameters:
//    OFFSET          page-offset bit count (must be > 2)
//    TIMEOUT_CYCLES  PTE read wait limit (timeout build only)
//
//  Ports:
//    clock, reset_n        clock, synchronous active-low reset
//    miss_i, miss_vaddr_i  TLB miss strobe and faulting virtual address
//    ptbr_i                page-table base (byte address)
//    stall_o               pipeline hold, asserted in the miss cycle itself
//    mem_req_o/mem_addr_o  PTE read request and byte address
//    mem_ack_i/mem_rdata_i PTE read completion and data (bit 0 = valid)
//    w_virtual_page_o      TLB write VPN
//    w_phys_page_o         TLB write PPN
//    write_enable_o        TLB write strobe (one cycle)
//    refill_done_o         one-cycle refill-complete pulse
//    fault_o, fault_code_o one-cycle page fault pulse, 0=invalid 1=timeout
//    fault_vaddr_o         address of the most recently captured miss
//
//  Revision : 1.0 - initial release
// ============================================================================
module tlb_refill_ctrl #(
  parameter int OFFSET         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                miss_i,
  input  logic [31:0]         miss_vaddr_i,
  input  logic [31:0]         ptbr_i,
  output logic                stall_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [31-OFFSET:0]  w_virtual_page_o,
  output logic [31-OFFSET:0]  w_phys_page_o,
  output logic                write_enable_o,
  output logic                refill_done_o,
  output logic                fault_o,
  output logic                fault_code_o,
  output logic [31:0]         fault_vaddr_o
);

  localparam int VPN_W = 32 - OFFSET;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [VPN_W-1:0]   r_vpn;
  logic [VPN_W-1:0]   r_ppn;
  logic [31:0]        r_pte_addr;
  logic [31:0]        r_fault_vaddr;

  logic               w_capture;
  logic               w_take_pte;
  logic               w_timeout;
  logic               w_fault_code;

  logic [VPN_W-1:0]   w_miss_vpn;
  logic [31:0]        w_pte_offset;
  logic [31:0]        w_pte_addr;

  // PTE address: base plus VPN scaled to 4-byte entries. The 32-bit add
  // discards the carry, so addresses wrap around the top of memory.
  assign w_miss_vpn   = miss_vaddr_i[31:OFFSET];
  assign w_pte_offset = {{(OFFSET-2){1'b0}}, w_miss_vpn, 2'b00};
  assign w_pte_addr   = ptbr_i + w_pte_offset;

  // PTE flag bits other than valid are not used by this block.
  logic w_unused_pte_bits;
  assign w_unused_pte_bits = ^mem_rdata_i[OFFSET-1:1];

  // --------------------------------------------------------------------------
  // Optional wait counter. It is cleared when a miss is captured (entry to
  // REQ) and counts REQ cycles without ack. The timeout fires on the cycle
  // that would bring it to TIMEOUT_CYCLES; an ack in that same cycle takes
  // priority in the next-state logic.
  // --------------------------------------------------------------------------
`ifdef TLB_REFILL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fault_code;

  assign w_timeout    = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_fault_code = r_fault_code;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wait_cnt   <= '0;
      r_fault_code <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_REQ) && !mem_ack_i) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Leaving REQ for FAULT without an ack can only be the timeout path.
      if ((r_state == S_REQ) && (w_state_next == S_FAULT)) begin
        r_fault_code <= ~mem_ack_i;
      end
    end
  end
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

  assign w_timeout    = 1'b0;
  assign w_fault_code = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Refill context: VPN, PTE address and faulting address are latched with
  // the miss; the PPN is latched with the ack.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_vpn         <= '0;
      r_ppn         <= '0;
      r_pte_addr    <= '0;
      r_fault_vaddr <= '0;
    end else begin
      if (w_capture) begin
        r_vpn         <= w_miss_vpn;
        r_pte_addr    <= w_pte_addr;
        r_fault_vaddr <= miss_vaddr_i;
      end
      if (w_take_pte) begin
        r_ppn <= mem_rdata_i[31:OFFSET];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. All outputs except stall_o are pure
  // functions of registered state, so they are glitch-free and zero in any
  // state that does not own them.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_capture        = 1'b0;
    w_take_pte       = 1'b0;
    mem_req_o        = 1'b0;
    mem_addr_o       = '0;
    write_enable_o   = 1'b0;
    w_virtual_page_o = '0;
    w_phys_page_o    = '0;
    refill_done_o    = 1'b0;
    fault_o          = 1'b0;
    fault_code_o     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (miss_i) begin
          w_capture    = 1'b1;
          w_state_next = S_REQ;
        end
      end

      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_pte_addr;
        if (mem_ack_i) begin
          w_take_pte   = 1'b1;
          w_state_next = mem_rdata_i[0] ? S_WRITE : S_FAULT;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end
      end

      S_WRITE: begin
        write_enable_o   = 1'b1;
        w_virtual_page_o = r_vpn;
        w_phys_page_o    = r_ppn;
        w_state_next     = S_DONE;
      end

      // miss_i is not looked at here: the TLB needs this cycle to re-look-up
      // with the new entry before a fresh miss is accepted.
      S_DONE: begin
        refill_done_o = 1'b1;
        w_state_next  = S_IDLE;
      end

      S_FAULT: begin
        fault_o      = 1'b1;
        fault_code_o = w_fault_code;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Combinational hold so the pipeline freezes in the cycle the miss appears.
  assign stall_o       = (r_state != S_IDLE) | miss_i;
  assign fault_vaddr_o = r_fault_vaddr;

endmodule
`default_nettype wire

// File: tb/tb_tlb_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlb_refill_ctrl
//  Purpose  : Directed self-checking bench for tlb_refill_ctrl (OFFSET=12).
//             Inputs change 1 time unit after the rising edge; outputs are
//             sampled on the falling edge of the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_refill_ctrl;

  localparam int OFFSET = 12;
  localparam int VPN_W  = 32 - OFFSET;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              miss_i;
  logic [31:0]       miss_vaddr_i;
  logic [31:0]       ptbr_i;
  logic              stall_o;
  logic              mem_req_o;
  logic [31:0]       mem_addr_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;
  logic [VPN_W-1:0]  w_virtual_page_o;
  logic [VPN_W-1:0]  w_phys_page_o;
  logic              write_enable_o;
  logic              refill_done_o;
  logic              fault_o;
  logic              fault_code_o;
  logic [31:0]       fault_vaddr_o;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  tlb_refill_ctrl #(
    .OFFSET         (OFFSET),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .miss_i           (miss_i),
    .miss_vaddr_i     (miss_vaddr_i),
    .ptbr_i           (ptbr_i),
    .stall_o          (stall_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rdata_i      (mem_rdata_i),
    .w_virtual_page_o (w_virtual_page_o),
    .w_phys_page_o    (w_phys_page_o),
    .write_enable_o   (write_enable_o),
    .refill_done_o    (refill_done_o),
    .fault_o          (fault_o),
    .fault_code_o     (fault_code_o),
    .fault_vaddr_o    (fault_vaddr_o)
  );

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; miss_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    miss_vaddr_i = 32'h1234_5678; ptbr_i = 32'h0;
    adv(); adv();
    mid();
    total++;
    if ({stall_o, mem_req_o, write_enable_o, refill_done_o, fault_o, fault_code_o} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 000000",
        {stall_o, mem_req_o, write_enable_o, refill_done_o, fault_o, fault_code_o});
    end
    total++;
    if (mem_addr_o !== 32'h0 || fault_vaddr_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr: got addr=%h fva=%h want 0/0", mem_addr_o, fault_vaddr_o);
    end
    total++;
    if (w_virtual_page_o !== '0 || w_phys_page_o !== '0) begin
      bad++; $display("FAIL reset_wpage: got %h/%h want 0/0", w_virtual_page_o, w_phys_page_o);
    end
    adv();
    reset_n = 1'b1;
    adv();
  endtask

  task automatic test_valid_refill();
    logic [31:0] exp_addr;
    exp_addr = 32'h0001_0000 + (32'h0000_0403 << 2);
    // cycle 0
    miss_i = 1'b1; miss_vaddr_i = 32'h0040_3ABC; ptbr_i = 32'h0001_0000;
    mid();
    total++;
    if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL valid_c0: got stall=%b req=%b want 1/0", stall_o, mem_req_o);
    end
    adv(); // cycle 1
    miss_i = 1'b0; miss_vaddr_i = 32'hDEAD_BEEF; ptbr_i = 32'h0;
    mid();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
      bad++; $display("FAIL valid_req: got req=%b addr=%h want 1/%h", mem_req_o, mem_addr_o, exp_addr);
    end
    adv(); // cycle 2
    mid();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr || stall_o !== 1'b1) begin
      bad++; $display("FAIL valid_hold: got req=%b addr=%h stall=%b want 1/%h/1",
        mem_req_o, mem_addr_o, stall_o, exp_addr);
    end
    adv(); // cycle 3
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0007_7001;
    mid();
    total++;
    if (write_enable_o !== 1'b0 || stall_o !== 1'b1) begin
      bad++; $display("FAIL valid_ack: got we=%b stall=%b want 0/1", write_enable_o, stall_o);
    end
    adv(); // cycle 4
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mid();
    total++;
    if (write_enable_o !== 1'b1 || w_virtual_page_o !== 20'h00403 || w_phys_page_o !== 20'h00077 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL valid_write: got we=%b vpn=%h ppn=%h req=%b want 1/00403/00077/0",
        write_enable_o, w_virtual_page_o, w_phys_page_o, mem_req_o);
    end
    adv(); // cycle 5: a miss here must be ignored
    miss_i = 1'b1; miss_vaddr_i = 32'h0099_9000;
    mid();
    total++;
    if (refill_done_o !== 1'b1 || write_enable_o !== 1'b0 || w_virtual_page_o !== '0 || w_phys_page_o !== '0) begin
      bad++; $display("FAIL valid_done: got done=%b we=%b vpn=%h ppn=%h want 1/0/0/0",
        refill_done_o, write_enable_o, w_virtual_page_o, w_phys_page_o);
    end
    adv(); // cycle 6
    miss_i = 1'b0;
    mid();
    total++;
    if (stall_o !== 1'b0 || refill_done_o !== 1'b0 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL valid_idle: got stall=%b done=%b req=%b want 0/0/0", stall_o, refill_done_o, mem_req_o);
    end
    adv(); // cycle 7
    mid();
    total++;
    if (mem_req_o !== 1'b0 || fault_vaddr_o !== 32'h0040_3ABC) begin
      bad++; $display("FAIL done_miss_ignored: got req=%b fva=%h want 0/00403abc", mem_req_o, fault_vaddr_o);
    end
    adv();
  endtask

  // Invalid PTE, then a new miss in the first IDLE cycle after FAULT whose
  // PTE address wraps past 2^32.
  task automatic test_back_to_back();
    miss_i = 1'b1; miss_vaddr_i = 32'h0040_3ABC; ptbr_i = 32'h0001_0000;
    adv(); // cycle 1
    miss_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h0007_7000;
    mid();
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++; $display("FAIL inv_req: got %b want 1", mem_req_o);
    end
    adv(); // cycle 2: FAULT
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mid();
    total++;
    if (fault_o !== 1'b1 || fault_code_o !== 1'b0 || write_enable_o !== 1'b0 || mem_req_o !== 1'b0 || stall_o !== 1'b1) begin
      bad++; $display("FAIL inv_fault: got f=%b code=%b we=%b req=%b stall=%b want 1/0/0/0/1",
        fault_o, fault_code_o, write_enable_o, mem_req_o, stall_o);
    end
    total++;
    if (fault_vaddr_o !== 32'h0040_3ABC) begin
      bad++; $display("FAIL inv_vaddr: got %h want 00403abc", fault_vaddr_o);
    end
    adv(); // cycle 3: first IDLE, new miss
    miss_i = 1'b1; miss_vaddr_i = 32'h0000_8123; ptbr_i = 32'hFFFF_FFF0;
    mid();
    total++;
    if (fault_o !== 1'b0 || stall_o !== 1'b1) begin
      bad++; $display("FAIL b2b_idle: got f=%b stall=%b want 0/1", fault_o, stall_o);
    end
    adv(); // cycle 4
    miss_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hABCD_E001;
    mid();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0010) begin
      bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/00000010", mem_req_o, mem_addr_o);
    end
    total++;
    if (fault_vaddr_o !== 32'h0000_8123) begin
      bad++; $display("FAIL b2b_vaddr: got %h want 00008123", fault_vaddr_o);
    end
    adv(); // cycle 5
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mid();
    total++;
    if (write_enable_o !== 1'b1 || w_virtual_page_o !== 20'h00008 || w_phys_page_o !== 20'hABCDE) begin
      bad++; $display("FAIL b2b_write: got we=%b vpn=%h ppn=%h want 1/00008/abcde",
        write_enable_o, w_virtual_page_o, w_phys_page_o);
    end
    adv(); // cycle 6
    mid();
    total++;
    if (refill_done_o !== 1'b1) begin
      bad++; $display("FAIL b2b_done: got %b want 1", refill_done_o);
    end
    adv(); // cycle 7
    mid();
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL b2b_end: got stall=%b want 0", stall_o);
    end
    adv();
  endtask

  task automatic test_reset_mid_req();
    miss_i = 1'b1; miss_vaddr_i = 32'h0040_3ABC; ptbr_i = 32'h0001_0000;
    adv(); // cycle 1
    miss_i = 1'b0;
    mid();
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++; $display("FAIL rst_req: got %b want 1", mem_req_o);
    end
    adv(); // cycle 2
    reset_n = 1'b0;
    adv(); // cycle 3
    reset_n = 1'b1;
    mid();
    total++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || fault_vaddr_o !== 32'h0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got req=%b addr=%h fva=%h stall=%b want 0/0/0/0",
        mem_req_o, mem_addr_o, fault_vaddr_o, stall_o);
    end
    adv(); // cycle 4: stray ack
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0007_7001;
    adv(); // cycle 5
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mid();
    total++;
    if (write_enable_o !== 1'b0 || fault_o !== 1'b0 || refill_done_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL rst_stray_ack: got we=%b f=%b done=%b stall=%b want 0/0/0/0",
        write_enable_o, fault_o, refill_done_o, stall_o);
    end
    adv(); // cycle 6
    mid();
    total++;
    if (write_enable_o !== 1'b0 || refill_done_o !== 1'b0 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL rst_after: got we=%b done=%b req=%b want 0/0/0", write_enable_o, refill_done_o, mem_req_o);
    end
    adv();
  endtask

`ifdef TLB_REFILL_TIMEOUT_EN
  task automatic test_timeout();
    int errs;
    errs = 0;
    miss_i = 1'b1; miss_vaddr_i = 32'h0012_3456; ptbr_i = 32'h0;
    adv();
    miss_i = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      mid();
      if (mem_req_o !== 1'b1 || fault_o !== 1'b0) errs++;
      adv();
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL to_wait: got %0d bad wait cycles want 0", errs);
    end
    mid(); // cycle 65
    total++;
    if (mem_req_o !== 1'b0 || fault_o !== 1'b1 || fault_code_o !== 1'b1) begin
      bad++; $display("FAIL to_fault: got req=%b f=%b code=%b want 0/1/1", mem_req_o, fault_o, fault_code_o);
    end
    adv();
    mid();
    total++;
    if (fault_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL to_idle: got f=%b stall=%b want 0/0", fault_o, stall_o);
    end
    adv();
    // ack on cycle 64 coincides with the timeout and must win
    miss_i = 1'b1; miss_vaddr_i = 32'h0012_3456;
    adv();
    miss_i = 1'b0;
    for (int c = 1; c <= 63; c++) adv();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0005_5001;
    adv(); // cycle 65
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mid();
    total++;
    if (write_enable_o !== 1'b1 || fault_o !== 1'b0 || w_phys_page_o !== 20'h00055) begin
      bad++; $display("FAIL to_ack_wins: got we=%b f=%b ppn=%h want 1/0/00055", write_enable_o, fault_o, w_phys_page_o);
    end
    adv();
    mid();
    total++;
    if (refill_done_o !== 1'b1) begin
      bad++; $display("FAIL to_ack_done: got %b want 1", refill_done_o);
    end
    adv();
  endtask
`else
  task automatic test_long_wait();
    int errs;
    errs = 0;
    miss_i = 1'b1; miss_vaddr_i = 32'h0012_3456; ptbr_i = 32'h0;
    adv();
    miss_i = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      mid();
      if (mem_req_o !== 1'b1 || fault_o !== 1'b0 || stall_o !== 1'b1) errs++;
      adv();
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL long_wait: got %0d bad wait cycles want 0", errs);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0005_5001;
    adv();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mid();
    total++;
    if (write_enable_o !== 1'b1 || w_virtual_page_o !== 20'h00123 || w_phys_page_o !== 20'h00055) begin
      bad++; $display("FAIL long_write: got we=%b vpn=%h ppn=%h want 1/00123/00055",
        write_enable_o, w_virtual_page_o, w_phys_page_o);
    end
    adv();
    adv();
  endtask
`endif

  initial begin
    test_reset();
    test_valid_refill();
    test_back_to_back();
    test_reset_mid_req();
`ifdef TLB_REFILL_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
